bicubic_product_normalize: RTL and testbench

//  Downstream stage of the 4x4 weight-matrix x pixel-vector multiplier. Takes one group of four

---
 rtl/bicubic_product_normalize.sv | 177 +++++++++++++++++
 tb/tb_bicubic_product_normalize.sv | 428 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bicubic_product_normalize.sv
// bicubic_product_normalize
// Final stage of the bicubic 4x4 weight x pixel multiplier.
// Takes four sign-magnitude inner products per beat and converts each to two's complement.
// Rounds away the fixed-point weight fraction, clamps each lane to the pixel range,
// and emits a packed four-pixel group with an end-of-line flag.
// The datapath is a two-stage valid/ready pipeline with a single global stall.
// Optional feature: define BICUBIC_NORM_SAT_COUNT_EN to add the saturating clamp-event counter
// and its sat_count port.

module bicubic_product_normalize #(
    parameter int PRODUCT_WIDTH = 32,
    parameter int FRAC_BITS     = 8,
    parameter int PIXEL_WIDTH   = 8,
    parameter int LINE_GROUPS   = 960
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [PRODUCT_WIDTH-2:0]   inner_product1,
    input  logic [PRODUCT_WIDTH-2:0]   inner_product2,
    input  logic [PRODUCT_WIDTH-2:0]   inner_product3,
    input  logic [PRODUCT_WIDTH-2:0]   inner_product4,
    input  logic                       inner_product_sign1,
    input  logic                       inner_product_sign2,
    input  logic                       inner_product_sign3,
    input  logic                       inner_product_sign4,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [4*PIXEL_WIDTH-1:0]   out_pixels,
    output logic                       out_eol
`ifdef BICUBIC_NORM_SAT_COUNT_EN
    ,
    output logic [15:0]                sat_count
`endif
);

    localparam int MAG_W = PRODUCT_WIDTH - 1;
    localparam int VAL_W = PRODUCT_WIDTH + 1;
    localparam int CNT_W = (LINE_GROUPS > 1) ? $clog2(LINE_GROUPS) : 1;

    localparam logic [CNT_W-1:0] LAST_GROUP = CNT_W'(LINE_GROUPS - 1);
    localparam logic signed [VAL_W-1:0] ROUND_HALF =
        {{(VAL_W-1){1'b0}}, 1'b1} << (FRAC_BITS - 1);
    localparam logic signed [VAL_W-1:0] PIX_MAX =
        {{(VAL_W-PIXEL_WIDTH){1'b0}}, {PIXEL_WIDTH{1'b1}}};

    logic [MAG_W-1:0]          mag [4];
    logic                      neg [4];

    logic                      adv;
    logic signed [VAL_W-1:0]   val_c [4];
    logic signed [VAL_W-1:0]   sum_c [4];
    logic signed [VAL_W-1:0]   q_c   [4];
    logic signed [VAL_W-1:0]   s1_q  [4];
    logic                      s1_valid;
    logic                      s2_valid;
    logic [4*PIXEL_WIDTH-1:0]  pix_c;
    logic [4*PIXEL_WIDTH-1:0]  s2_pix;
    logic [CNT_W-1:0]          line_cnt;

    assign mag[0] = inner_product1;
    assign mag[1] = inner_product2;
    assign mag[2] = inner_product3;
    assign mag[3] = inner_product4;
    assign neg[0] = inner_product_sign1;
    assign neg[1] = inner_product_sign2;
    assign neg[2] = inner_product_sign3;
    assign neg[3] = inner_product_sign4;

    // One stall signal for the whole pipe: everything moves only when the output slot frees up
    assign adv        = !s2_valid || out_ready;
    assign in_ready   = adv;
    assign out_valid  = s2_valid;
    assign out_pixels = s2_pix;
    assign out_eol    = s2_valid && (line_cnt == LAST_GROUP);

    // S1 arithmetic: sign-magnitude to two's complement, then round half up and drop the fraction
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            val_c[i] = neg[i] ? -$signed({2'b00, mag[i]}) : $signed({2'b00, mag[i]});
            sum_c[i] = val_c[i] + ROUND_HALF;
            q_c[i]   = sum_c[i] >>> FRAC_BITS;
        end
    end

    // S2 arithmetic: clamp each rounded lane into the unsigned pixel range
    always_comb begin
        pix_c = '0;
        for (int i = 0; i < 4; i++) begin
            if (s1_q[i] < 0) begin
                pix_c[i*PIXEL_WIDTH +: PIXEL_WIDTH] = '0;
            end else if (s1_q[i] > PIX_MAX) begin
                pix_c[i*PIXEL_WIDTH +: PIXEL_WIDTH] = '1;
            end else begin
                pix_c[i*PIXEL_WIDTH +: PIXEL_WIDTH] = s1_q[i][PIXEL_WIDTH-1:0];
            end
        end
    end

    // Pipeline registers; reset empties both stages so in-flight groups are discarded
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s2_pix   <= '0;
            for (int i = 0; i < 4; i++) begin
                s1_q[i] <= '0;
            end
        end else if (adv) begin
            s1_valid <= in_valid;
            s1_q     <= q_c;
            s2_valid <= s1_valid;
            s2_pix   <= pix_c;
        end
    end

    // Position of the current output group within the line, advanced per output transfer
    always_ff @(posedge clk) begin
        if (rst) begin
            line_cnt <= '0;
        end else if (s2_valid && out_ready) begin
            if (line_cnt == LAST_GROUP) begin
                line_cnt <= '0;
            end else begin
                line_cnt <= line_cnt + 1'b1;
            end
        end
    end

`ifdef BICUBIC_NORM_SAT_COUNT_EN
    logic [3:0]  clamp_c;
    logic [3:0]  s2_clamp;
    logic [2:0]  clamp_sum;
    logic [16:0] sat_sum;

    // Per-lane clamp flags, derived from the same S1 values the pixel clamp uses
    always_comb begin
        clamp_c = '0;
        for (int i = 0; i < 4; i++) begin
            clamp_c[i] = (s1_q[i] < 0) || (s1_q[i] > PIX_MAX);
        end
    end

    // Number of clamped lanes in the group sitting at the output, and the tentative new total
    always_comb begin
        clamp_sum = {2'b00, s2_clamp[0]} + {2'b00, s2_clamp[1]}
                  + {2'b00, s2_clamp[2]} + {2'b00, s2_clamp[3]};
        sat_sum   = {1'b0, sat_count} + {14'd0, clamp_sum};
    end

    // Clamp flags travel with their group through S2 so they are counted at the transfer
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_clamp <= '0;
        end else if (adv) begin
            s2_clamp <= clamp_c;
        end
    end

    // Saturating event counter: sticks at all-ones instead of wrapping
    always_ff @(posedge clk) begin
        if (rst) begin
            sat_count <= '0;
        end else if (s2_valid && out_ready) begin
            if (sat_sum[16]) begin
                sat_count <= 16'hFFFF;
            end else begin
                sat_count <= sat_sum[15:0];
            end
        end
    end
`else
    // Without the counter no clamp flags are kept; the pixel datapath is unchanged
`endif

endmodule

// File: tb/tb_bicubic_product_normalize.sv
// tb_bicubic_product_normalize
// Random and directed stimulus against a plain-arithmetic reference model of the
// normalize stage (LINE_GROUPS reduced to 4 so line boundaries come often).
// Define BICUBIC_NORM_SAT_COUNT_EN to also exercise the saturating clamp counter.

module tb_bicubic_product_normalize;

    localparam int PW   = 32;
    localparam int FB   = 8;
    localparam int PXW  = 8;
    localparam int LG   = 4;

    typedef struct {
        logic [31:0] pix;
        int          ncl;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [30:0] ip1, ip2, ip3, ip4;
    logic        is1, is2, is3, is4;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pixels;
    logic        out_eol;
`ifdef BICUBIC_NORM_SAT_COUNT_EN
    logic [15:0] sat_count;
`endif

    int   total;
    int   bad;
    exp_t exp_q[$];
    int   line_idx;
    int   xfer_total;
    int   eol_seen;
    int   sat_model;
    bit   held;
    logic [31:0] held_pix;
    logic        held_eol;

    bicubic_product_normalize #(
        .PRODUCT_WIDTH (PW),
        .FRAC_BITS     (FB),
        .PIXEL_WIDTH   (PXW),
        .LINE_GROUPS   (LG)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .in_valid            (in_valid),
        .in_ready            (in_ready),
        .inner_product1      (ip1),
        .inner_product2      (ip2),
        .inner_product3      (ip3),
        .inner_product4      (ip4),
        .inner_product_sign1 (is1),
        .inner_product_sign2 (is2),
        .inner_product_sign3 (is3),
        .inner_product_sign4 (is4),
        .out_valid           (out_valid),
        .out_ready           (out_ready),
        .out_pixels          (out_pixels),
        .out_eol             (out_eol)
`ifdef BICUBIC_NORM_SAT_COUNT_EN
        ,
        .sat_count           (sat_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: exact rational value mag/2^FB (signed), rounded half up via floor division
    function automatic longint rounded(input bit s, input longint mag);
        longint v;
        longint t;
        longint d;
        v = s ? -mag : mag;
        d = longint'(1) << FB;
        t = v + d / 2;
        if (t >= 0) return t / d;
        return -((-t + d - 1) / d);
    endfunction

    function automatic exp_t model_group(input logic [30:0] m1, m2, m3, m4,
                                         input logic [3:0] s);
        exp_t   e;
        longint q;
        longint mags[4];
        mags[0] = longint'(m1);
        mags[1] = longint'(m2);
        mags[2] = longint'(m3);
        mags[3] = longint'(m4);
        e.pix = '0;
        e.ncl = 0;
        for (int i = 0; i < 4; i++) begin
            q = rounded(s[i], mags[i]);
            if (q < 0) begin
                e.ncl++;
            end else if (q > 255) begin
                e.pix[i*8 +: 8] = 8'hFF;
                e.ncl++;
            end else begin
                e.pix[i*8 +: 8] = 8'(q);
            end
        end
        return e;
    endfunction

    function automatic logic [30:0] rand_mag();
        case ($urandom_range(0, 3))
            0:       return 31'($urandom);
            1:       return 31'($urandom_range(0, 32'h0001_FFFF));
            default: return 31'($urandom_range(0, 32'h0000_FFFF));
        endcase
    endfunction

    // Output monitor: scoreboard, end-of-line model, hold stability and stall rule
    always begin
        @(negedge clk);
        #3;
        if (rst) begin
            exp_q.delete();
            line_idx  = 0;
            held      = 1'b0;
            sat_model = 0;
        end else begin
            total++;
            if (in_ready !== (!out_valid || out_ready)) begin
                bad++;
                $display("[TB] FAIL in_ready_rule: in_ready=%b out_valid=%b out_ready=%b",
                         in_ready, out_valid, out_ready);
            end
`ifdef BICUBIC_NORM_SAT_COUNT_EN
            total++;
            if (sat_count !== 16'(sat_model)) begin
                bad++;
                $display("[TB] FAIL sat_count: got %h expected %h", sat_count, 16'(sat_model));
            end
`endif
            if (out_valid === 1'b1) begin
                if (held) begin
                    total++;
                    if (out_pixels !== held_pix || out_eol !== held_eol) begin
                        bad++;
                        $display("[TB] FAIL hold_stable: got %h/%b expected %h/%b",
                                 out_pixels, out_eol, held_pix, held_eol);
                    end
                end
                if (out_ready) begin
                    exp_t e;
                    held = 1'b0;
                    total++;
                    if (exp_q.size() == 0) begin
                        bad++;
                        $display("[TB] FAIL unexpected_output: got %h expected none", out_pixels);
                    end else begin
                        e = exp_q.pop_front();
                        if (out_pixels !== e.pix) begin
                            bad++;
                            $display("[TB] FAIL pixels: got %h expected %h", out_pixels, e.pix);
                        end
                        sat_model = sat_model + e.ncl;
                        if (sat_model > 65535) sat_model = 65535;
                    end
                    total++;
                    if (out_eol !== (line_idx == LG - 1)) begin
                        bad++;
                        $display("[TB] FAIL eol: got %b expected %b (group %0d of line)",
                                 out_eol, (line_idx == LG - 1), line_idx + 1);
                    end
                    if (out_eol === 1'b1) eol_seen++;
                    line_idx = (line_idx + 1) % LG;
                    xfer_total++;
                end else begin
                    held     = 1'b1;
                    held_pix = out_pixels;
                    held_eol = out_eol;
                end
            end else begin
                held = 1'b0;
            end
        end
    end

    // Present one group and hold it until the stage accepts it; record the expectation on accept
    task automatic drive_group(input logic [30:0] m1, m2, m3, m4, input logic [3:0] s);
        bit ok;
        ok = 1'b0;
        @(negedge clk);
        ip1 = m1; ip2 = m2; ip3 = m3; ip4 = m4;
        is1 = s[0]; is2 = s[1]; is3 = s[2]; is4 = s[3];
        in_valid = 1'b1;
        for (int c = 0; c < 200; c++) begin
            #1;
            if (in_ready) begin
                exp_q.push_back(model_group(m1, m2, m3, m4, s));
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            total++;
            bad++;
            $display("[TB] FAIL accept_timeout: got in_ready=0 expected 1 within 200 cycles");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drive_random();
        drive_group(rand_mag(), rand_mag(), rand_mag(), rand_mag(), 4'($urandom));
    endtask

    task automatic wait_drain();
        for (int c = 0; c < 100; c++) begin
            if (exp_q.size() == 0 && out_valid === 1'b0) break;
            @(posedge clk);
        end
        #4;
        total++;
        if (exp_q.size() != 0 || out_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        #1;
        total++;
        if (out_valid !== 1'b0 || out_pixels !== 32'h0 || out_eol !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("[TB] FAIL reset_state: got v=%b pix=%h eol=%b rdy=%b expected 0/0/0/1",
                     out_valid, out_pixels, out_eol, in_ready);
        end
`ifdef BICUBIC_NORM_SAT_COUNT_EN
        total++;
        if (sat_count !== 16'h0) begin
            bad++;
            $display("[TB] FAIL reset_sat: got %h expected 0000", sat_count);
        end
`endif
    endtask

    task automatic test_rounding();
        drive_group(31'h1280, 31'h127F, 31'h0080, 31'h007F, 4'b0000);
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL latency_early: got out_valid=%b expected 0", out_valid);
        end
        @(posedge clk);
        #1;
        total++;
        if (out_valid !== 1'b1 || out_pixels !== 32'h0001_1213) begin
            bad++;
            $display("[TB] FAIL rounding: got v=%b pix=%h expected 1/00011213", out_valid, out_pixels);
        end
        wait_drain();
    endtask

    task automatic test_clamp();
        drive_group(31'h500, 31'h20000, 31'h0, 31'hFF00, 4'b0101);
        @(posedge clk);
        #1;
        total++;
        if (out_pixels !== 32'hFF00_FF00) begin
            bad++;
            $display("[TB] FAIL clamp: got %h expected ff00ff00", out_pixels);
        end
        wait_drain();
    endtask

    task automatic test_backpressure();
        int start;
        start = xfer_total;
        fork
            begin
                for (int g = 0; g < 6; g++) drive_random();
            end
            begin
                repeat (3) @(negedge clk);
                out_ready = 1'b0;
                repeat (5) @(negedge clk);
                out_ready = 1'b1;
            end
        join
        wait_drain();
        total++;
        if (xfer_total - start != 6) begin
            bad++;
            $display("[TB] FAIL backpressure_count: got %0d expected 6", xfer_total - start);
        end
    endtask

    task automatic test_eol();
        int eol_start;
        apply_reset();
        eol_start = eol_seen;
        for (int g = 0; g < 8; g++) drive_random();
        wait_drain();
        total++;
        if (eol_seen - eol_start != 2) begin
            bad++;
            $display("[TB] FAIL eol_count: got %0d expected 2", eol_seen - eol_start);
        end
        drive_random();
        wait_drain();
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b0;
        drive_random();
        drive_random();
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (out_valid !== 1'b0 || out_eol !== 1'b0) begin
            bad++;
            $display("[TB] FAIL midstream_reset: got v=%b eol=%b expected 0/0", out_valid, out_eol);
        end
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_capture: got out_valid=%b expected 0", out_valid);
        end
        for (int g = 0; g < 4; g++) drive_random();
        wait_drain();
    endtask

    task automatic test_back_to_back();
        bit done;
        done = 1'b0;
        fork
            begin
                for (int g = 0; g < 40; g++) drive_random();
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(negedge clk);
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        wait_drain();
    endtask

`ifdef BICUBIC_NORM_SAT_COUNT_EN
    task automatic test_sat_count();
        apply_reset();
        drive_group(31'h20000, 31'h500, 31'h30000, 31'h10, 4'b0010);
        drive_group(31'h20000, 31'h500, 31'h30000, 31'h10, 4'b0010);
        wait_drain();
        total++;
        if (sat_count !== 16'd6) begin
            bad++;
            $display("[TB] FAIL sat_six: got %0d expected 6", sat_count);
        end
        for (int g = 0; g < 16382; g++) drive_group(31'h20000, 31'h20000, 31'h20000, 31'h20000, 4'b0000);
        wait_drain();
        total++;
        if (sat_count !== 16'hFFFE) begin
            bad++;
            $display("[TB] FAIL sat_preload: got %h expected fffe", sat_count);
        end
        drive_group(31'h20000, 31'h900, 31'h20000, 31'h900, 4'b1010);
        wait_drain();
        total++;
        if (sat_count !== 16'hFFFF) begin
            bad++;
            $display("[TB] FAIL sat_ceiling: got %h expected ffff", sat_count);
        end
    endtask
`endif

    initial begin
        total      = 0;
        bad        = 0;
        line_idx   = 0;
        xfer_total = 0;
        eol_seen   = 0;
        sat_model  = 0;
        held       = 1'b0;
        rst        = 1'b1;
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        ip1 = '0; ip2 = '0; ip3 = '0; ip4 = '0;
        is1 = 1'b0; is2 = 1'b0; is3 = 1'b0; is4 = 1'b0;
        test_reset();
        test_rounding();
        test_clamp();
        test_backpressure();
        test_eol();
        test_reset_midstream();
        test_back_to_back();
`ifdef BICUBIC_NORM_SAT_COUNT_EN
        test_sat_count();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
